// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register
// pending scoreboard that raises stall on RAW/WAW hazards against in-flight writes.
module regfile_scoreboard #(
  parameter int unsigned nregs = 32,
  parameter int unsigned nbits = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(nregs)-1:0] rs1_addr,
  input  logic                     rs1_en,
  output logic [nbits-1:0]         rs1_data,
  input  logic [$clog2(nregs)-1:0] rs2_addr,
  input  logic                     rs2_en,
  output logic [nbits-1:0]         rs2_data,
  input  logic                     issue_val,
  input  logic [$clog2(nregs)-1:0] issue_waddr,
  input  logic                     wb_en,
  input  logic [$clog2(nregs)-1:0] wb_addr,
  input  logic [nbits-1:0]         wb_data,
  output logic                     stall,
  output logic [nregs-1:0]         pending
);

  localparam int unsigned aw = $clog2(nregs);

  logic [nbits-1:0] regs [nregs];
  logic [nregs-1:0] pending_nxt;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             issue_fire;

  // Operand reads: bypass the writeback value when it targets the same non-zero register
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != aw'(0))) rs1_data = wb_data;
    if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != aw'(0))) rs2_data = wb_data;
  end

  // Hazards: a pending register being written back this cycle is already safe
  always_comb begin
    raw1  = rs1_en && (rs1_addr != aw'(0)) && pending[rs1_addr]
            && !(wb_en && (wb_addr == rs1_addr));
    raw2  = rs2_en && (rs2_addr != aw'(0)) && pending[rs2_addr]
            && !(wb_en && (wb_addr == rs2_addr));
    waw   = issue_val && (issue_waddr != aw'(0)) && pending[issue_waddr]
            && !(wb_en && (wb_addr == issue_waddr));
    stall = raw1 || raw2 || waw;
    issue_fire = issue_val && !stall;
  end

  // Clear on writeback first, then set on issue so the newer writer owns the register
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (issue_fire && (issue_waddr != aw'(0))) pending_nxt[issue_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int unsigned i = 0; i < nregs; i++) regs[i] <= '0;
    end else begin
      pending <= pending_nxt;
      if (wb_en && (wb_addr != aw'(0))) regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic, compared against an array-based reference model of the register file.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, issue_waddr, wb_addr;
  logic        rs1_en, rs2_en, issue_val, wb_en;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        stall;
  logic [31:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  regfile_scoreboard #(.nregs(32), .nbits(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_en(rs1_en), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_en(rs2_en), .rs2_data(rs2_data),
    .issue_val(issue_val), .issue_waddr(issue_waddr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: operand value seen by the ALU this cycle
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return (a != 5'd0) && m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic m_stall();
    return (rs1_en && m_busy(rs1_addr)) || (rs2_en && m_busy(rs2_addr))
           || (issue_val && m_busy(issue_waddr));
  endfunction

  function automatic logic [31:0] m_pvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    bit fire;
    fire = issue_val && !m_stall();
    if (rst) m_reset();
    else begin
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (wb_en) m_pend[wb_addr] = 1'b0;
      if (fire && issue_waddr != 5'd0) m_pend[issue_waddr] = 1'b1;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance, check pending
  task automatic cycle();
    @(negedge clk);
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("stall", 32'(stall), 32'(m_stall()));
    @(posedge clk);
    m_edge();
    #1;
    chk("pending", pending, m_pvec());
  endtask

  task automatic idle();
    rst = 1'b0; rs1_en = 1'b0; rs2_en = 1'b0; issue_val = 1'b0; wb_en = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; issue_waddr = 5'd0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    idle();
    m_reset();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset, then every register reads zero
    cycle();
    rst = 1'b0;
    chk("rst_pending", pending, 32'd0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i + 1); rs1_en = 1'b1; rs2_en = 1'b1;
      #1 chk("rst_read", rs1_data, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      cycle();
    end
    idle();

    // Basic write/read and x0
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; cycle();
    idle(); rs1_addr = 5'd5;
    #1 chk("x5_read", rs1_data, 32'hDEADBEEF); cycle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs1_addr = 5'd0;
    #1 chk("x0_bypass", rs1_data, 32'd0); cycle();
    idle();
    #1 chk("x0_read", rs1_data, 32'd0); cycle();

    // Same-cycle bypass on rs2
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5; rs2_addr = 5'd7;
    #1 chk("bypass_rs2", rs2_data, 32'hA5A5A5A5); cycle();
    idle();

    // RAW stall and release
    issue_val = 1'b1; issue_waddr = 5'd3; cycle();
    chk("pend3_set", 32'(pending[3]), 32'd1);
    idle(); rs1_en = 1'b1; rs1_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", 32'(stall), 32'd1); cycle();
    end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h42;
    #1 chk("raw_release", 32'(stall), 32'd0);
    chk("raw_bypass", rs1_data, 32'h42); cycle();
    chk("pend3_clr", 32'(pending[3]), 32'd0);
    idle(); issue_val = 1'b1; issue_waddr = 5'd3; cycle();
    idle(); rs1_addr = 5'd3;
    #1 chk("raw_no_en", 32'(stall), 32'd0); cycle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h43; cycle();
    idle();

    // WAW and same-edge set/clear
    issue_val = 1'b1; issue_waddr = 5'd9; cycle();
    #1 chk("waw_stall", 32'(stall), 32'd1); cycle();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1 chk("waw_release", 32'(stall), 32'd0); cycle();
    chk("set_wins", 32'(pending[9]), 32'd1);
    idle(); issue_val = 1'b1; issue_waddr = 5'd0;
    #1 chk("x0_issue_stall", 32'(stall), 32'd0); cycle();
    chk("x0_issue_pend", pending, 32'h0000_0200);
    idle(); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h98; cycle();
    idle();

    // Reset mid-operation
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd7; cycle();
    idle(); issue_val = 1'b1; issue_waddr = 5'd4; cycle();
    issue_waddr = 5'd12; cycle();
    idle(); rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h55;
    issue_val = 1'b1; issue_waddr = 5'd20; cycle();
    chk("rst_mid_pend", pending, 32'd0);
    idle(); rs1_addr = 5'd4; rs2_addr = 5'd12;
    #1 chk("rst_mid_x4", rs1_data, 32'd0);
    chk("rst_mid_x12", rs2_data, 32'd0); cycle();

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      rs1_en      = 1'($urandom);
      rs2_en      = 1'($urandom);
      rs1_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      issue_val   = 1'($urandom);
      issue_waddr = 5'($urandom_range(0, 7));
      wb_en       = ($urandom_range(0, 2) != 0);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
